// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
//   Shared definitions for the LED pattern generator:
//     - mode_t      : pattern mode encodings (COUNT / ROTATE / PINGPONG / BLINK)
//     - pp_state_t  : ping-pong direction state (PP_LEFT / PP_RIGHT)
//     - SEED_*      : pattern value loaded when a mode is entered
//     - seed_value  : maps a mode to its seed
//   No ports (package).
// -----------------------------------------------------------------------------
package led_pkg;

   typedef enum logic [1:0] {
      MODE_COUNT    = 2'd0,
      MODE_ROTATE   = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_BLINK    = 2'd3
   } mode_t;

   // PP_LEFT walks the lit bit toward the MSB, PP_RIGHT toward the LSB.
   typedef enum logic {
      PP_LEFT  = 1'b0,
      PP_RIGHT = 1'b1
   } pp_state_t;

   // Seeds are either all-zero or a single lit LSB, so they are kept as small
   // integers and widened to LED_N at the point of use.
   localparam int unsigned SEED_COUNT    = 0;
   localparam int unsigned SEED_ROTATE   = 1;
   localparam int unsigned SEED_PINGPONG = 1;
   localparam int unsigned SEED_BLINK    = 0;

   function automatic int unsigned seed_value(input mode_t m);
      int unsigned s;
      s = SEED_COUNT;
      case (m)
         MODE_COUNT:    s = SEED_COUNT;
         MODE_ROTATE:   s = SEED_ROTATE;
         MODE_PINGPONG: s = SEED_PINGPONG;
         MODE_BLINK:    s = SEED_BLINK;
         default:       s = SEED_COUNT;
      endcase
      return s;
   endfunction

endpackage : led_pkg

// File: rtl/led_prescaler.sv
// -----------------------------------------------------------------------------
// led_prescaler
//   Divides clk into a one-cycle step tick. The counter runs 0..PRESCALE-1
//   while en=1 and holds its value while en=0, so a paused period resumes
//   exactly where it stopped. clr restarts the period and masks the tick in
//   the same cycle.
//
// Parameters
//   PRESCALE    clk cycles per tick (>= 2)
//   PRESCALE_W  counter width, 2^PRESCALE_W >= PRESCALE
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   en     in   1 = count, 0 = hold
//   clr    in   synchronous restart of the period (overrides en)
//   tick   out  high during the cycle the count equals PRESCALE-1 (and en=1)
// -----------------------------------------------------------------------------
module led_prescaler #(
   parameter int unsigned PRESCALE   = 8388608,
   parameter int unsigned PRESCALE_W = 23
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);
   localparam logic [PRESCALE_W-1:0] ONE  = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] cnt;
   logic                  at_last;

   assign at_last = (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         if (at_last) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + ONE;
         end
      end
   end

   // A clr cycle never produces a tick: the step it would cause is dropped.
   assign tick = en & at_last & ~clr;

endmodule : led_prescaler

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//   LED pattern generator for the board LED bank. A prescaler produces a step
//   tick; every tick advances the pattern according to the selected mode:
//     COUNT    binary up/down counter (dir)
//     ROTATE   circular shift left/right (dir)
//     PINGPONG single lit LED bouncing between the ends (dir ignored)
//     BLINK    whole bank toggles (dir ignored)
//   A change of mode reloads the mode seed and restarts the prescaler period
//   on the next edge, independent of en. led_out is a registered copy of the
//   pattern (one cycle behind it).
//
// Optional feature (macro LED_PWM_EN)
//   Adds the duty port and a free-running PWM_W-bit counter; led_out is the
//   pattern gated by (pwm_cnt < duty). Without the macro there is no duty
//   port and led_out follows the pattern directly.
//
// Parameters
//   LED_N       number of LEDs (>= 2)
//   PRESCALE    clk cycles per step tick (>= 2)
//   PRESCALE_W  prescaler width, 2^PRESCALE_W >= PRESCALE
//   PWM_W       brightness counter width (LED_PWM_EN builds only)
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   en       in   1 = run, 0 = freeze prescaler and pattern
//   mode     in   [1:0] 0 COUNT, 1 ROTATE, 2 PINGPONG, 3 BLINK
//   dir      in   COUNT/ROTATE: 1 = up/left, 0 = down/right
//   duty     in   [PWM_W-1:0] brightness (LED_PWM_EN builds only)
//   tick     out  one-cycle pulse on each pattern step
//   led_out  out  [LED_N-1:0] LED drive, active-high
// -----------------------------------------------------------------------------
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int unsigned LED_N      = 4,
   parameter int unsigned PRESCALE   = 8388608,
   parameter int unsigned PRESCALE_W = 23,
   parameter int unsigned PWM_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             dir,
`ifdef LED_PWM_EN
   input  logic [PWM_W-1:0] duty,
`endif
   output logic             tick,
   output logic [LED_N-1:0] led_out
);

   localparam logic [LED_N-1:0] ONE = LED_N'(1);

   mode_t            mode_sel;
   mode_t            mode_q;
   logic             mode_chg;
   logic             step;
   logic [LED_N-1:0] pattern;
   logic [LED_N-1:0] pattern_next;
   logic [LED_N-1:0] seed;

   // Ping-pong FSM
   pp_state_t        pp_state;
   pp_state_t        pp_next;
   logic [LED_N-1:0] pp_pattern;

   assign mode_sel = mode_t'(mode);
   assign mode_chg = (mode_sel != mode_q);
   assign seed     = LED_N'(seed_value(mode_sel));

   // ---------------------------------------------------------------------------
   // Step tick. A pending mode change clears the period and masks the tick, so
   // the seed is never stepped in the cycle it is loaded.
   // ---------------------------------------------------------------------------
   led_prescaler #(
      .PRESCALE   (PRESCALE),
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (mode_chg),
      .tick  (step)
   );

   assign tick = step;

   // ---------------------------------------------------------------------------
   // Ping-pong FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pp_state <= PP_LEFT;
      end else if (mode_chg) begin
         pp_state <= PP_LEFT;
      end else if (step && (mode_q == MODE_PINGPONG)) begin
         pp_state <= pp_next;
      end
   end

   // Ping-pong FSM: next state. The direction flips when the lit bit has
   // reached the end it was travelling toward.
   always_comb begin
      pp_next = pp_state;
      case (pp_state)
         PP_LEFT:  if (pattern[LED_N-1]) pp_next = PP_RIGHT;
         PP_RIGHT: if (pattern[0])       pp_next = PP_LEFT;
         default:  pp_next = PP_LEFT;
      endcase
   end

   // Ping-pong FSM: output (next pattern). At an end the bit bounces back in
   // the same step, so each end LED is lit for exactly one step.
   always_comb begin
      pp_pattern = pattern << 1;
      case (pp_state)
         PP_LEFT: begin
            if (pattern[LED_N-1]) pp_pattern = pattern >> 1;
            else                  pp_pattern = pattern << 1;
         end
         PP_RIGHT: begin
            if (pattern[0]) pp_pattern = pattern << 1;
            else            pp_pattern = pattern >> 1;
         end
         default: pp_pattern = pattern << 1;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Pattern step per mode. Arithmetic wraps naturally at LED_N bits.
   // ---------------------------------------------------------------------------
   always_comb begin
      pattern_next = pattern;
      case (mode_q)
         MODE_COUNT: begin
            if (dir) pattern_next = pattern + ONE;
            else     pattern_next = pattern - ONE;
         end
         MODE_ROTATE: begin
            if (dir) pattern_next = {pattern[LED_N-2:0], pattern[LED_N-1]};
            else     pattern_next = {pattern[0], pattern[LED_N-1:1]};
         end
         MODE_PINGPONG: pattern_next = pp_pattern;
         MODE_BLINK:    pattern_next = ~pattern;
         default:       pattern_next = pattern;
      endcase
   end

   // mode_q resets to COUNT, whose seed (0) matches the reset pattern.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q  <= MODE_COUNT;
         pattern <= '0;
      end else if (mode_chg) begin
         mode_q  <= mode_sel;
         pattern <= seed;
      end else if (step) begin
         pattern <= pattern_next;
      end
   end

   // ---------------------------------------------------------------------------
   // LED output register (with optional brightness gate)
   // ---------------------------------------------------------------------------
`ifdef LED_PWM_EN
   logic [PWM_W-1:0] pwm_cnt;
   logic             pwm_on;

   // Free-running regardless of en so a frozen pattern still dims correctly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
   end

   // duty=0 never lights; the maximum duty lights all but one count per period.
   assign pwm_on = (pwm_cnt < duty);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_out <= '0;
      end else begin
         led_out <= pattern & {LED_N{pwm_on}};
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_out <= '0;
      end else begin
         led_out <= pattern;
      end
   end
`endif

endmodule : led_pattern_gen

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//   Bench for led_pattern_gen with LED_N=4, PRESCALE=4, PWM_W=4.
//   A reference model computes the expected tick and led_out from the mode
//   rules (counter arithmetic, ping-pong phase table) and a monitor compares
//   them on every falling edge. Directed sequences add literal expectations.
//   Define LED_PWM_EN to exercise the brightness gate.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

   localparam int LED_N    = 4;
   localparam int PRESCALE = 4;
   localparam int PWM_W    = 4;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic             clk   = 1'b0;
   logic             reset = 1'b1;
   logic             en    = 1'b0;
   logic [1:0]       mode  = 2'd0;
   logic             dir   = 1'b1;
`ifdef LED_PWM_EN
   logic [PWM_W-1:0] duty  = 4'd15;
`endif
   logic             tick;
   logic [LED_N-1:0] led_out;

   always #5 clk = ~clk;

   led_pattern_gen #(
      .LED_N      (LED_N),
      .PRESCALE   (PRESCALE),
      .PRESCALE_W (2),
      .PWM_W      (PWM_W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .mode    (mode),
      .dir     (dir),
`ifdef LED_PWM_EN
      .duty    (duty),
`endif
      .tick    (tick),
      .led_out (led_out)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard bookkeeping
   // ---------------------------------------------------------------------------
   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   int         m_cnt    = 0;   // position within the step period
   int         m_phase  = 0;   // ping-pong phase 0..5
   int         m_mode_q = 0;
   logic [3:0] m_pat    = 4'h0;
   logic [3:0] m_led    = 4'h0;

   // Ping-pong visits bit positions 0,1,2,3,2,1 and repeats.
   function automatic logic [3:0] pp_pat(input int ph);
      if (ph < 4) return 4'(1 << ph);
      return 4'(1 << (6 - ph));
   endfunction

   function automatic logic [3:0] step_pat(input int m, input logic d, input logic [3:0] p);
      int v;
      v = int'(p);
      case (m)
         0:       v = d ? (v + 1) % 16 : (v + 15) % 16;
         1:       v = d ? ((v * 2) % 16 + v / 8) : (v / 2 + (v % 2) * 8);
         default: v = 15 - v;
      endcase
      return 4'(v);
   endfunction

`ifdef LED_PWM_EN
   int m_pwm = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) m_pwm <= 0;
      else       m_pwm <= (m_pwm + 1) % 16;
   end

   // Value the output register captures at the coming edge.
   function automatic logic [3:0] model_led(input logic [3:0] p);
      return (m_pwm < int'(duty)) ? p : 4'h0;
   endfunction

   // Expected led_out for a literal pattern, sampled between edges: the gate
   // used was the counter value before the last edge.
   function automatic logic [3:0] lit(input logic [3:0] p);
      return (((m_pwm + 15) % 16) < int'(duty)) ? p : 4'h0;
   endfunction
`else
   function automatic logic [3:0] model_led(input logic [3:0] p);
      return p;
   endfunction

   function automatic logic [3:0] lit(input logic [3:0] p);
      return p;
   endfunction
`endif

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt    <= 0;
         m_phase  <= 0;
         m_mode_q <= 0;
         m_pat    <= 4'h0;
         m_led    <= 4'h0;
      end else begin
         m_led <= model_led(m_pat);
         if (int'(mode) != m_mode_q) begin
            m_mode_q <= int'(mode);
            m_cnt    <= 0;
            m_phase  <= 0;
            m_pat    <= (mode == 2'd1 || mode == 2'd2) ? 4'h1 : 4'h0;
         end else if (en) begin
            if (m_cnt == PRESCALE - 1) begin
               m_cnt <= 0;
               if (m_mode_q == 2) begin
                  m_phase <= (m_phase + 1) % 6;
                  m_pat   <= pp_pat((m_phase + 1) % 6);
               end else begin
                  m_pat <= step_pat(m_mode_q, dir, m_pat);
               end
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   // Monitor: every falling edge, DUT against model.
   always @(negedge clk) begin
      check("tick", 32'(tick),
            32'(en && !reset && (m_cnt == PRESCALE - 1) && (int'(mode) == m_mode_q)));
      check("led_out", 32'(led_out), 32'(m_led));
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   // Waits (bounded) for a tick; n = falling edges consumed.
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tick && n < 20);
      if (!tick) check("tick_timeout", 32'(tick), 32'd1);
   endtask

   // Next step must show exp on led_out: one edge for the pattern, one for
   // the output register.
   task automatic next_step(input logic [3:0] exp, input string name);
      int n;
      wait_tick(n);
      @(negedge clk);
      @(negedge clk);
      check(name, 32'(led_out), 32'(lit(exp)));
   endtask

   task automatic run_table(input string name);
      while (exp_q.size() > 0) next_step(exp_q.pop_front(), name);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int lat;
      int cnt_t;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_led", 32'(led_out), 32'h0);
      check("reset_tick", 32'(tick), 32'h0);

      // Release with en=1: four enabled cycles to the first tick
      #1 reset = 1'b0; en = 1'b1;
      lat = 1;
      do begin
         @(negedge clk);
         lat++;
      end while (!tick && lat < 20);
      check("first_tick_latency", 32'(lat), 32'd4);

      // COUNT up from 0: 0001..1111, 0000, 0001
      @(negedge clk);
      @(negedge clk);
      check("count_up", 32'(led_out), 32'(lit(4'h1)));
      for (int k = 2; k <= 17; k++) next_step(4'(k % 16), "count_up");

      // COUNT down from a fresh seed (leave and re-enter COUNT)
      #1 mode = 2'd3;
      @(negedge clk);
      #1 mode = 2'd0; dir = 1'b0;
      next_step(4'hF, "count_down");
      next_step(4'hE, "count_down");

      // ROTATE right then left from seed 0001
      #1 mode = 2'd1;
      exp_q = '{4'h8, 4'h4, 4'h2, 4'h1};
      run_table("rotate_right");
      #1 dir = 1'b1;
      exp_q = '{4'h2, 4'h4, 4'h8, 4'h1};
      run_table("rotate_left");

      // PINGPONG, dir ignored
      #1 mode = 2'd2; dir = 1'b0;
      exp_q = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};
      run_table("pingpong");

      // Pause mid-period: value held, no tick, count resumes where it stopped
      #1 en = 1'b0;
      cnt_t = 0;
      repeat (10) begin
         @(negedge clk);
         if (tick) cnt_t++;
      end
      check("hold_ticks", 32'(cnt_t), 32'd0);
      check("hold_led", 32'(led_out), 32'(lit(4'h4)));
      #1 en = 1'b1;
      wait_tick(lat);
      check("resume_latency", 32'(lat), 32'd2);
      @(negedge clk);
      @(negedge clk);
      check("pingpong_resume", 32'(led_out), 32'(lit(4'h8)));

      // COUNT -> BLINK mid-period: seed 0 next edge, period restarted
      #1 mode = 2'd0; dir = 1'b1;
      next_step(4'h1, "count_after_pp");
      #1 mode = 2'd3;
      @(negedge clk);
      @(negedge clk);
      check("blink_seed", 32'(led_out), 32'(lit(4'h0)));
      wait_tick(lat);
      check("switch_tick_latency", 32'(lat), 32'd2);
      @(negedge clk);
      @(negedge clk);
      check("blink_first", 32'(led_out), 32'(lit(4'hF)));
      next_step(4'h0, "blink_second");
      next_step(4'hF, "blink_third");

      // Asynchronous reset while a tick is high and the bank is lit
      wait_tick(lat);
      #1 reset = 1'b1;
      #1;
      check("async_reset_led", 32'(led_out), 32'h0);
      check("async_reset_tick", 32'(tick), 32'h0);
      mode = 2'd0;
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b0;
      lat = 1;
      do begin
         @(negedge clk);
         lat++;
      end while (!tick && lat < 20);
      check("post_reset_latency", 32'(lat), 32'd4);
      @(negedge clk);
      @(negedge clk);
      check("post_reset_count", 32'(led_out), 32'(lit(4'h1)));

`ifdef LED_PWM_EN
      // Brightness: BLINK frozen at 1111
      #1 mode = 2'd3;
      next_step(4'hF, "pwm_blink_on");
      #1 en = 1'b0; duty = 4'd4;
      @(negedge clk);
      cnt_t = 0;
      repeat (16) begin
         @(negedge clk);
         if (led_out == 4'hF) cnt_t++;
      end
      check("pwm_duty4_on", 32'(cnt_t), 32'd4);
      #1 duty = 4'd0;
      @(negedge clk);
      cnt_t = 0;
      repeat (16) begin
         @(negedge clk);
         if (led_out != 4'h0) cnt_t++;
      end
      check("pwm_duty0_on", 32'(cnt_t), 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_led_pattern_gen
